// File: rtl/router_pkg.sv
// Shared types and defaults for the router address generator.
package router_pkg;
  localparam int AG_SA_HEIGHT   = 4;
  localparam int AG_SA_BITS     = $clog2(AG_SA_HEIGHT);
  localparam int AG_KERNEL_SIZE = 3;
  localparam int AG_ADDR_WIDTH  = 6;
  localparam int WINDOW         = AG_KERNEL_SIZE * AG_KERNEL_SIZE;

  typedef enum logic {AG_IDLE, AG_GEN} ag_state_t;

  typedef struct packed {
    logic [AG_ADDR_WIDTH-1:0] o_x;
    logic [AG_ADDR_WIDTH-1:0] o_y;
    logic [AG_SA_BITS-1:0]    row_number;
  } ag_req_t;
endpackage

// File: rtl/router_window_counter.sv
// Nested kx/ky window counter: ky is the inner loop, kx the outer.
module router_window_counter #(
  parameter int KERNEL_SIZE = 3,
  parameter int CW          = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load,
  input  logic          advance,
  output logic [CW-1:0] kx,
  output logic [CW-1:0] ky,
  output logic          last,
  output logic          wrap
);
  localparam logic [CW-1:0] KMAX = CW'(KERNEL_SIZE - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kx <= '0;
      ky <= '0;
    end else if (clear || load) begin
      kx <= '0;
      ky <= '0;
    end else if (advance) begin
      if (ky == KMAX) begin
        ky <= '0;
        kx <= (kx == KMAX) ? '0 : kx + 1'b1;
      end else begin
        ky <= ky + 1'b1;
      end
    end
  end

  assign last = (kx == KMAX) && (ky == KMAX);
  assign wrap = advance && last;
endmodule

// File: rtl/router_addr_gen.sv
// Streams the KxK input-buffer read addresses of one convolution window per request.
// Optional zero padding is enabled with ROUTER_ADDR_GEN_PADDING_EN.
module router_addr_gen
  import router_pkg::*;
#(
  parameter int SA_HEIGHT   = AG_SA_HEIGHT,
  parameter int KERNEL_SIZE = AG_KERNEL_SIZE,
  parameter int ADDR_WIDTH  = AG_ADDR_WIDTH,
  localparam int SA_BITS    = $clog2(SA_HEIGHT)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_reg_clear,
  input  logic                  i_en,
  input  logic [ADDR_WIDTH-1:0] i_o_x,
  input  logic [ADDR_WIDTH-1:0] i_o_y,
  input  logic [SA_BITS-1:0]    i_row_number,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [ADDR_WIDTH-1:0] i_i_size,
  input  logic [ADDR_WIDTH-1:0] i_stride,
`ifdef ROUTER_ADDR_GEN_PADDING_EN
  input  logic [ADDR_WIDTH-1:0] i_pad,
  output logic                  o_pad_zero,
`endif
  input  logic                  i_ready,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_valid,
  output logic [SA_BITS-1:0]    o_row_number,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow
);
  localparam int CW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

  ag_state_t state, state_n;
  ag_req_t   req, req_n, pend, pend_n, in_req;
  logic      pend_vld, pend_vld_n, overflow, overflow_n, done;
  logic      load_cnt, fire, win_end, last;
  logic [CW-1:0] kx, ky;

  assign in_req = '{o_x: i_o_x, o_y: i_o_y, row_number: i_row_number};
  assign fire   = (state == AG_GEN) && i_ready;

  router_window_counter #(.KERNEL_SIZE(KERNEL_SIZE), .CW(CW)) u_cnt (
    .clk(i_clk), .rst(i_rst), .clear(i_reg_clear), .load(load_cnt),
    .advance(fire), .kx(kx), .ky(ky), .last(last), .wrap(win_end)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= AG_IDLE; req <= '0; pend <= '0; pend_vld <= 1'b0;
      overflow <= 1'b0; done <= 1'b0;
    end else if (i_reg_clear) begin
      state <= AG_IDLE; req <= '0; pend <= '0; pend_vld <= 1'b0;
      overflow <= 1'b0; done <= 1'b0;
    end else begin
      state <= state_n; req <= req_n; pend <= pend_n; pend_vld <= pend_vld_n;
      overflow <= overflow_n; done <= win_end;
    end
  end

  always_comb begin
    state_n    = state;
    req_n      = req;
    pend_n     = pend;
    pend_vld_n = pend_vld;
    overflow_n = overflow;
    load_cnt   = 1'b0;
    case (state)
      AG_IDLE: if (i_en) begin
        req_n = in_req; state_n = AG_GEN; load_cnt = 1'b1;
      end
      AG_GEN: begin
        // A full slot at the start of the cycle always drops, even on the window's last beat.
        if (i_en && pend_vld) overflow_n = 1'b1;
        if (win_end) begin
          if (pend_vld) begin
            req_n = pend; pend_vld_n = 1'b0; load_cnt = 1'b1;
          end else if (i_en) begin
            req_n = in_req; load_cnt = 1'b1;
          end else begin
            state_n = AG_IDLE;
          end
        end else if (i_en && !pend_vld) begin
          pend_n = in_req; pend_vld_n = 1'b1;
        end
      end
      default: state_n = AG_IDLE;
    endcase
  end

  logic [ADDR_WIDTH-1:0] addr;
`ifdef ROUTER_ADDR_GEN_PADDING_EN
  localparam int EW = ADDR_WIDTH + 2;
  logic [EW-1:0] ex, ey;
  logic          pad_hit;
  assign ex = EW'(req.o_x) * EW'(i_stride) + EW'(kx) - EW'(i_pad);
  assign ey = EW'(req.o_y) * EW'(i_stride) + EW'(ky) - EW'(i_pad);
  // The sign bit catches the negative side, so the upper compare can stay unsigned.
  assign pad_hit = ex[EW-1] || ey[EW-1] || (ex >= EW'(i_i_size)) || (ey >= EW'(i_i_size));
  assign addr = pad_hit ? '0
              : i_start_addr + ex[ADDR_WIDTH-1:0] * i_i_size + ey[ADDR_WIDTH-1:0];
  assign o_pad_zero = (state == AG_GEN) && pad_hit;
`else
  logic [ADDR_WIDTH-1:0] rx, ry;
  assign rx   = req.o_x * i_stride + ADDR_WIDTH'(kx);
  assign ry   = req.o_y * i_stride + ADDR_WIDTH'(ky);
  assign addr = i_start_addr + rx * i_i_size + ry;
`endif

  assign o_valid      = (state == AG_GEN);
  assign o_addr       = o_valid ? addr : '0;
  assign o_row_number = o_valid ? req.row_number : '0;
  assign o_last       = o_valid && last;
  assign o_busy       = o_valid || pend_vld;
  assign o_done       = done;
  assign o_overflow   = overflow;
endmodule

// File: tb/tb_router_addr_gen.sv
// Directed and randomized checks of router_addr_gen against a window-list reference model.
module tb_router_addr_gen;
  logic       clk, rst, reg_clear, en, ready;
  logic [5:0] o_x, o_y, start, size, stride, pad;
  logic [1:0] row;
  logic [5:0] addr;
  logic [1:0] row_out;
  logic       valid, last, busy, done, overflow, pad_zero;

  router_addr_gen dut (
    .i_clk(clk), .i_rst(rst), .i_reg_clear(reg_clear), .i_en(en),
    .i_o_x(o_x), .i_o_y(o_y), .i_row_number(row),
    .i_start_addr(start), .i_i_size(size), .i_stride(stride),
`ifdef ROUTER_ADDR_GEN_PADDING_EN
    .i_pad(pad), .o_pad_zero(pad_zero),
`endif
    .i_ready(ready), .o_addr(addr), .o_valid(valid), .o_row_number(row_out),
    .o_last(last), .o_busy(busy), .o_done(done), .o_overflow(overflow)
  );
`ifndef ROUTER_ADDR_GEN_PADDING_EN
  assign pad_zero = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] addr;
    logic [1:0] row;
    logic       last;
    logic       padz;
  } beat_t;

  beat_t      q[$];
  logic [5:0] alog[$];
  logic       plog[$];
  int         windows, checks, errors;
  logic       done_exp, ovf_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Every beat of a window, straight from the address formula and scan order.
  function automatic void push_window(int x, int y, int r);
    for (int kx = 0; kx < 3; kx++)
      for (int ky = 0; ky < 3; ky++) begin
        beat_t b;
        int cx, cy, a;
        cx = x * int'(stride) + kx;
        cy = y * int'(stride) + ky;
        b.row  = r[1:0];
        b.last = (kx == 2) && (ky == 2);
        b.padz = 1'b0;
`ifdef ROUTER_ADDR_GEN_PADDING_EN
        cx = cx - int'(pad);
        cy = cy - int'(pad);
        if (cx < 0 || cy < 0 || cx >= int'(size) || cy >= int'(size)) b.padz = 1'b1;
`endif
        a = int'(start) + cx * int'(size) + cy;
        b.addr = b.padz ? 6'd0 : a[5:0];
        q.push_back(b);
      end
  endfunction

  task automatic check_outputs();
    if (rst) begin
      chk("rst_valid", valid, 0); chk("rst_addr", addr, 0); chk("rst_row", row_out, 0);
      chk("rst_last", last, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
      chk("rst_ovf", overflow, 0); chk("rst_padz", pad_zero, 0);
    end else begin
      chk("valid", valid, q.size() > 0);
      chk("busy", busy, windows > 0);
      chk("done", done, done_exp);
      chk("overflow", overflow, ovf_exp);
      if (q.size() > 0) begin
        chk("addr", addr, q[0].addr);
        chk("row", row_out, q[0].row);
        chk("last", last, q[0].last);
        chk("pad_zero", pad_zero, q[0].padz);
      end
    end
  endtask

  task automatic update_model();
    int pre;
    if (rst || reg_clear) begin
      q.delete(); windows = 0; done_exp = 1'b0; ovf_exp = 1'b0;
      return;
    end
    pre = windows;
    done_exp = 1'b0;
    if (q.size() > 0 && ready) begin
      beat_t b;
      b = q.pop_front();
      alog.push_back(b.addr);
      plog.push_back(b.padz);
      if (b.last) begin done_exp = 1'b1; windows--; end
    end
    if (en) begin
      if (pre < 2) begin push_window(int'(o_x), int'(o_y), int'(row)); windows++; end
      else ovf_exp = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic request(input int x, input int y, input int r);
    en = 1'b1; o_x = x[5:0]; o_y = y[5:0]; row = r[1:0];
    tick();
    en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) tick();
    chk("drain_empty", q.size(), 0);
  endtask

  int exp1[9]  = '{8, 9, 10, 14, 15, 16, 20, 21, 22};
  int exp3[18] = '{0, 1, 2, 6, 7, 8, 12, 13, 14, 1, 2, 3, 7, 8, 9, 13, 14, 15};

  initial begin
    checks = 0; errors = 0; windows = 0; done_exp = 1'b0; ovf_exp = 1'b0;
    rst = 1'b1; reg_clear = 1'b0; en = 1'b0; ready = 1'b1;
    o_x = '0; o_y = '0; row = '0; start = '0; size = 6'd6; stride = 6'd1; pad = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // basic window
    alog.delete();
    request(1, 2, 2);
    repeat (12) tick();
    chk("t1_count", alog.size(), 9);
    for (int i = 0; i < 9 && i < alog.size(); i++) chk("t1_seq", alog[i], exp1[i]);

    // stall on the third beat
    alog.delete();
    request(1, 2, 2);
    tick(); tick();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); chk("t2_hold", addr, 10); end
    ready = 1'b1;
    repeat (10) tick();
    chk("t2_count", alog.size(), 9);
    for (int i = 0; i < 9 && i < alog.size(); i++) chk("t2_seq", alog[i], exp1[i]);

    // back-to-back with a dropped third request
    alog.delete();
    request(0, 0, 0);
    request(0, 1, 1);
    request(0, 2, 3);
    chk("t3_ovf", overflow, 1);
    repeat (20) tick();
    chk("t3_count", alog.size(), 18);
    for (int i = 0; i < 18 && i < alog.size(); i++) chk("t3_seq", alog[i], exp3[i]);
    reg_clear = 1'b1; tick(); reg_clear = 1'b0;
    chk("t3_ovf_cleared", overflow, 0);

    // stride 2
    alog.delete();
    stride = 6'd2; size = 6'd8; start = 6'd4;
    request(1, 1, 1);
    repeat (11) tick();
    chk("t4_count", alog.size(), 9);
    if (alog.size() == 9) begin chk("t4_first", alog[0], 22); chk("t4_last", alog[8], 40); end

    // reset mid-window
    stride = 6'd1; size = 6'd6; start = 6'd0;
    request(1, 2, 2);
    repeat (4) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    tick();
    chk("t5_no_done", done, 0);
    alog.delete();
    request(1, 2, 2);
    repeat (11) tick();
    chk("t5_count", alog.size(), 9);
    if (alog.size() > 0) chk("t5_first", alog[0], 8);

`ifdef ROUTER_ADDR_GEN_PADDING_EN
    alog.delete(); plog.delete();
    pad = 6'd1;
    request(0, 0, 0);
    repeat (11) tick();
    chk("t6_count", alog.size(), 9);
    if (alog.size() == 9) begin
      for (int i = 0; i < 9; i++)
        chk("t6_padz", plog[i], (i <= 3 || i == 6) ? 1 : 0);
      chk("t6_beat4", alog[4], 0);
      chk("t6_last", alog[8], 7);
    end
    pad = 6'd0;
`endif

    // randomized traffic
    for (int seg = 0; seg < 4; seg++) begin
      en = 1'b0; ready = 1'b1;
      drain();
      start  = 6'($urandom_range(0, 63));
      size   = 6'($urandom_range(1, 63));
      stride = 6'($urandom_range(1, 3));
`ifdef ROUTER_ADDR_GEN_PADDING_EN
      pad    = 6'($urandom_range(0, 2));
`endif
      for (int c = 0; c < 150; c++) begin
        en        = ($urandom_range(0, 3) == 0);
        ready     = ($urandom_range(0, 3) != 0);
        reg_clear = ($urandom_range(0, 99) == 0);
        o_x = 6'($urandom_range(0, 15));
        o_y = 6'($urandom_range(0, 15));
        row = 2'($urandom_range(0, 3));
        tick();
      end
      en = 1'b0; reg_clear = 1'b0; ready = 1'b1;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/router_addr_gen.md
Name: router_addr_gen

Overview:
- Address generator directly downstream of the router controller.
- Each enable pulse carries one output-feature-map coordinate (x, y) and a systolic-array row number. For each one, the block emits the KERNEL_SIZE×KERNEL_SIZE input-buffer read addresses of that convolution window, one per cycle, under valid/ready flow control.
- A one-deep pending slot absorbs a request that arrives while a window is still being streamed.

Parameters:
- SA_HEIGHT, 4, systolic-array rows; row tag width SA_BITS = $clog2(SA_HEIGHT).
- KERNEL_SIZE, 3, kernel edge length; window = KERNEL_SIZE² addresses.
- ADDR_WIDTH, 6, width of coordinates, sizes and addresses.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_reg_clear  in  1  synchronous clear of all state; same effect as reset.
- i_en  in  1  request strobe; samples i_o_x, i_o_y, i_row_number.
- i_o_x, i_o_y  in  ADDR_WIDTH  output pixel coordinate.
- i_row_number  in  SA_BITS  destination array row.
- i_start_addr  in  ADDR_WIDTH  input-buffer base address; quasi-static.
- i_i_size  in  ADDR_WIDTH  input feature-map edge length; quasi-static.
- i_stride  in  ADDR_WIDTH  convolution stride; quasi-static, ≥1.
- i_ready  in  1  downstream accepts o_addr this cycle.
- o_addr  out  ADDR_WIDTH  input-buffer read address.
- o_valid  out  1  o_addr is valid.
- o_row_number  out  SA_BITS  row tag travelling with o_addr.
- o_last  out  1  marks the final address of the window.
- o_busy  out  1  a window is streaming or a request is pending.
- o_done  out  1  one-cycle pulse after the last address is accepted.
- o_overflow  out  1  sticky: a request was dropped.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0. Reset mid-window aborts the window with no o_done.
- i_reg_clear has identical effect, synchronously; it takes priority over all other events in that cycle.
- FSM states:
  - IDLE: o_valid = 0. When i_en = 1, latch the coordinate and row, zero the kx/ky counters, go to GEN. o_valid rises the next cycle (latency 1).
  - GEN: o_valid = 1 and all outputs registered. On i_valid & i_ready, advance ky. When ky wraps, advance kx.
- Address: o_addr = i_start_addr + (o_x·stride + kx)·i_i_size + (o_y·stride + ky).
  - Computed modulo 2^ADDR_WIDTH; silent wrap; no saturation.
- Scan order: ky is the inner loop, kx the outer.
- o_last = 1 when kx = ky = KERNEL_SIZE−1.
- Window end: acceptance of the o_last beat pulses o_done in the next cycle.
  - If the pending slot is full, load it into the active registers and stay in GEN. o_valid stays high with no bubble.
  - Otherwise go to IDLE.
- Backpressure: while i_ready = 0, o_addr, o_row_number and o_last hold stable.
- i_en while in GEN:
  - Pending slot empty: capture the request into it.
  - Pending slot full: drop the request and set o_overflow. It clears only on reset or i_reg_clear.
- i_en in the same cycle the last beat is accepted, with pending empty: the request goes directly into the active registers. Back-to-back windows run with no bubble.
- o_busy = (state == GEN) | pending_valid.

Optional Feature:
- Macro: ROUTER_ADDR_GEN_PADDING_EN.
- Defined:
  - Adds input i_pad (ADDR_WIDTH) and output o_pad_zero (1).
  - Effective coordinates: cx = o_x·stride + kx − i_pad and cy = o_y·stride + ky − i_pad, computed signed at ADDR_WIDTH+2 bits.
  - If cx or cy < 0, or ≥ i_i_size: o_pad_zero = 1 and o_addr = 0. The beat is still emitted and handshaken normally.
- Undefined: neither port exists and the unpadded formula applies.

Decomposition:
- Package router_pkg holds:
  - the enum typedef ag_state_t {AG_IDLE, AG_GEN};
  - the request struct ag_req_t {o_x, o_y, row_number};
  - the localparam WINDOW = KERNEL_SIZE².
- One sub-module, router_window_counter: the kx/ky nested counter with advance input, wrap and last outputs.

Test Plan:
- K=3, stride=1, i_size=6, start=0, request (x=1, y=2, row=2), i_ready always 1 → o_addr sequence 8, 9, 10, 14, 15, 16, 20, 21, 22. o_row_number = 2 throughout; o_last only on 22; o_done one cycle later.
- Same stimulus with i_ready low on beats 3–5 → o_addr holds 10 while stalled. The full sequence and count are unchanged (9 beats).
- Requests (0,0), (0,1), (0,2) on consecutive cycles → third dropped and o_overflow = 1. First two windows stream back to back with no o_valid gap: 0,1,2,6,7,8,12,13,14 then 1,2,3,7,8,9,13,14,15.
- stride=2, i_size=8, start=4, request (1,1) → first address 22 (4 + 2·8 + 2); last address 40 (4 + 4·8 + 4).
- Assert i_rst mid-window at beat 4 → next cycle all outputs 0, no o_done. A new request afterwards starts at kx = ky = 0.
- With ROUTER_ADDR_GEN_PADDING_EN, i_pad=1, request (0,0), i_size=6 → o_pad_zero on beats 0, 1, 2, 3, 6. Beat 4 o_addr = 0 with o_pad_zero = 0; last beat o_addr = 7.
